// File: rtl/sint_ray_sched_pkg.sv
// Shared types for the scene-intersection ray scheduler and its neighbours.
package sint_ray_sched_pkg;

  typedef struct packed {
    logic [1:0]  ray_type;
    logic [13:0] ray_id;
    logic [31:0] payload;
  } shader_to_sint_t;

  localparam int unsigned STS_W = $bits(shader_to_sint_t);

  typedef enum logic {SRC_RG, SRC_SH} sched_src_e;

  typedef enum logic {StEmpty, StFull} sched_state_e;

endpackage

// File: rtl/ff_ar_en.sv
// Enabled flop bank with asynchronous active-low reset to a parameterised value.
module ff_ar_en #(
  parameter int unsigned       Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= ResetVal;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sint_ray_sched_phase_gen.sv
// Free-running three-phase one-hot ring (v0 -> v1 -> v2 -> v0) for multiphase pipelines.
module sint_ray_sched_phase_gen (
  input  logic clk,
  input  logic rst_n,
  output logic v0,
  output logic v1,
  output logic v2
);

  logic [2:0] ring_q;

  ff_ar_en #(
    .Width   (3),
    .ResetVal(3'b001)
  ) u_ring (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (1'b1),
    .d    ({ring_q[1:0], ring_q[2]}),
    .q    (ring_q)
  );

  assign v0 = ring_q[0];
  assign v1 = ring_q[1];
  assign v2 = ring_q[2];

endmodule

// File: rtl/sint_ray_sched.sv
// Feeds the scene-intersection unit: weighted raygen/shader arbitration, credit-limited issue,
// one-entry output register and the v0/v1/v2 phase enables.
module sint_ray_sched
  import sint_ray_sched_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 64,
  parameter int unsigned SH_WEIGHT    = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rg_valid,
  input  logic [STS_W-1:0]                  rg_data,
  output logic                              rg_stall,
  input  logic                              sh_valid,
  input  logic [STS_W-1:0]                  sh_data,
  output logic                              sh_stall,
  input  logic                              rg_pause,
  input  logic                              ray_retire,
  output logic                              sint_valid,
  output logic [STS_W-1:0]                  sint_data,
  input  logic                              sint_stall,
  output logic                              v0,
  output logic                              v1,
  output logic                              v2,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              idle
);

  localparam int unsigned InfW = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned CntW = (SH_WEIGHT > 0) ? $clog2(SH_WEIGHT + 1) : 1;

  logic             accept, loadable, credit_ok;
  logic             rg_req, rg_elig, sh_elig, rg_turn;
  logic             rg_grant, sh_grant, grant;
  sched_src_e       grant_src;
  logic [STS_W-1:0] grant_data;
  logic [CntW-1:0]  sh_cnt_d, sh_cnt_q;
  logic [InfW-1:0]  inflight_d, inflight_q;
  sched_state_e     state_d, state_q;
  logic             state_raw;

  sint_ray_sched_phase_gen u_phase_gen (
    .clk  (clk),
    .rst_n(rst),
    .v0   (v0),
    .v1   (v1),
    .v2   (v2)
  );

  // Arbitration: shader first, but a waiting raygen wins once the shader streak hits the weight.
  always_comb begin
    accept    = sint_valid & ~sint_stall;
    loadable  = ~sint_valid | accept;
    credit_ok = inflight_q < InfW'(MAX_INFLIGHT);
    rg_req    = rg_valid & ~rg_pause;
    rg_elig   = rg_req & loadable & credit_ok;
    sh_elig   = sh_valid & loadable & credit_ok;
    rg_turn   = (sh_cnt_q == CntW'(SH_WEIGHT));
    rg_grant  = rg_elig & (~sh_elig | rg_turn);
    sh_grant  = sh_elig & ~rg_grant;
    grant     = rg_grant | sh_grant;
    grant_src = rg_grant ? SRC_RG : SRC_SH;
  end

  always_comb begin
    grant_data = sh_data;
    unique case (grant_src)
      SRC_RG:  grant_data = rg_data;
      SRC_SH:  grant_data = sh_data;
      default: grant_data = sh_data;
    endcase
  end

  assign rg_stall = rg_valid & ~rg_grant;
  assign sh_stall = sh_valid & ~sh_grant;

  // The streak only matters while raygen is actually waiting for a turn.
  always_comb begin
    sh_cnt_d = sh_cnt_q;
    if (!rg_req || rg_grant) begin
      sh_cnt_d = '0;
    end else if (sh_grant && !rg_turn) begin
      sh_cnt_d = sh_cnt_q + CntW'(1);
    end
  end

  ff_ar_en #(
    .Width(CntW)
  ) u_sh_cnt (
    .clk  (clk),
    .rst_n(rst),
    .en   (1'b1),
    .d    (sh_cnt_d),
    .q    (sh_cnt_q)
  );

  // Credits are taken at grant time; a retire with nothing outstanding is dropped.
  always_comb begin
    inflight_d = inflight_q;
    if (grant && !ray_retire) begin
      inflight_d = inflight_q + InfW'(1);
    end else if (!grant && ray_retire && (inflight_q != '0)) begin
      inflight_d = inflight_q - InfW'(1);
    end
  end

  ff_ar_en #(
    .Width(InfW)
  ) u_inflight (
    .clk  (clk),
    .rst_n(rst),
    .en   (1'b1),
    .d    (inflight_d),
    .q    (inflight_q)
  );

  // Output register FSM: state register, next state, outputs.
  ff_ar_en #(
    .Width(1)
  ) u_state (
    .clk  (clk),
    .rst_n(rst),
    .en   (1'b1),
    .d    (logic'(state_d)),
    .q    (state_raw)
  );

  assign state_q = sched_state_e'(state_raw);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (grant) state_d = StFull;
      StFull:  if (accept && !grant) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    sint_valid = (state_q == StFull);
  end

  ff_ar_en #(
    .Width(STS_W)
  ) u_data (
    .clk  (clk),
    .rst_n(rst),
    .en   (grant),
    .d    (grant_data),
    .q    (sint_data)
  );

  assign inflight = inflight_q;
  assign idle     = (inflight_q == '0) & (state_q == StEmpty);

`ifndef SYNTH
  retire_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(ray_retire && (inflight_q == '0)))
    else $error("ray_retire with no rays in flight");
`endif

endmodule

// File: tb/tb_sint_ray_sched.sv
// Self-checking bench for sint_ray_sched: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_sint_ray_sched;
  import sint_ray_sched_pkg::*;

  localparam int unsigned MaxInf = 4;
  localparam int unsigned ShW    = 3;
  localparam int unsigned InfW   = $clog2(MaxInf + 1);
  localparam int unsigned DW     = STS_W;

  logic            clk = 1'b0;
  logic            rst;
  logic            rg_valid, sh_valid, rg_pause, ray_retire, sint_stall;
  logic [DW-1:0]   rg_data, sh_data;
  logic            rg_stall, sh_stall, sint_valid, v0, v1, v2, idle;
  logic [DW-1:0]   sint_data;
  logic [InfW-1:0] inflight;

  always #5 clk = ~clk;

  sint_ray_sched #(
    .MAX_INFLIGHT(MaxInf),
    .SH_WEIGHT   (ShW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rg_valid  (rg_valid),
    .rg_data   (rg_data),
    .rg_stall  (rg_stall),
    .sh_valid  (sh_valid),
    .sh_data   (sh_data),
    .sh_stall  (sh_stall),
    .rg_pause  (rg_pause),
    .ray_retire(ray_retire),
    .sint_valid(sint_valid),
    .sint_data (sint_data),
    .sint_stall(sint_stall),
    .v0        (v0),
    .v1        (v1),
    .v2        (v2),
    .inflight  (inflight),
    .idle      (idle)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one slot between requesters and sint, a credit count, a phase index and
  // the length of the current run of shader wins over a waiting raygen request.
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_inflight, m_phase, m_streak;

  bit            s_rg_xfer, s_sh_xfer, s_accept, s_valid, s_v2;
  logic [DW-1:0] s_data;

  typedef struct {
    int rg_v, rg_id, sh_v, sh_id, pause, retire, stall;
    int e_rgs, e_shs, e_val, e_id, e_inf;
  } vec_t;

  function automatic logic [DW-1:0] mk_ray(int id, logic [31:0] payload);
    shader_to_sint_t r;
    r.ray_type = 2'(id);
    r.ray_id   = 14'(id);
    r.payload  = payload;
    return r;
  endfunction

  function automatic int id_of(logic [DW-1:0] d);
    shader_to_sint_t r;
    r = d;
    return int'(r.ray_id);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid    = 0;
    m_data     = '0;
    m_inflight = 0;
    m_phase    = 0;
    m_streak   = 0;
    s_rg_xfer  = 0;
    s_sh_xfer  = 0;
    s_accept   = 0;
    s_valid    = 0;
  endtask

  task automatic clear_inputs();
    rg_valid   = 0;
    sh_valid   = 0;
    rg_data    = '0;
    sh_data    = '0;
    rg_pause   = 0;
    ray_retire = 0;
    sint_stall = 0;
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step();
    bit acc, room, credit, rg_req, rg_ok, sh_ok, e_rg, e_sh;
    logic [DW-1:0] rgd, shd;
    #1;
    acc    = m_valid && !sint_stall;
    room   = !m_valid || acc;
    credit = m_inflight < int'(MaxInf);
    rg_req = rg_valid && !rg_pause;
    rg_ok  = rg_req && room && credit;
    sh_ok  = sh_valid && room && credit;
    e_rg   = rg_ok && (!sh_ok || m_streak >= int'(ShW));
    e_sh   = sh_ok && !e_rg;
    chk("rg_stall", rg_stall, rg_valid && !e_rg);
    chk("sh_stall", sh_stall, sh_valid && !e_sh);
    chk("sint_valid", sint_valid, m_valid);
    if (m_valid) chk("sint_data", sint_data, m_data);
    chk("inflight", inflight, m_inflight);
    chk("phase", {v0, v1, v2}, 3'b100 >> m_phase);
    chk("idle", idle, (m_inflight == 0) && !m_valid);
    s_rg_xfer = rg_valid && !rg_stall;
    s_sh_xfer = sh_valid && !sh_stall;
    s_accept  = sint_valid && !sint_stall;
    s_valid   = sint_valid;
    s_data    = sint_data;
    s_v2      = v2;
    rgd       = rg_data;
    shd       = sh_data;
    @(posedge clk);
    if (e_rg || e_sh) begin
      m_valid = 1;
      m_data  = e_rg ? rgd : shd;
    end else if (acc) begin
      m_valid = 0;
    end
    if ((e_rg || e_sh) && !ray_retire) m_inflight++;
    else if (!(e_rg || e_sh) && ray_retire && m_inflight > 0) m_inflight--;
    if (!rg_req || e_rg) m_streak = 0;
    else if (e_sh) m_streak++;
    m_phase = (m_phase + 1) % 3;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    logic [2:0] pat[3];
    int grants, n_rg, n_sh, g, next_id, rid;
    int got[$];
    bit prev_hold;
    logic [DW-1:0] prev_data;

    rst = 0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;

    // Reset release: phase rotation with nothing requested.
    pat[0] = 3'b100;
    pat[1] = 3'b010;
    pat[2] = 3'b001;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("phase_seq", {v0, v1, v2}, pat[i % 3]);
      step();
    end

    //             rg_v id sh_v id pse ret stl | rgs shs val id inf
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    tbl[1] = '{1, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 5, 1};
    tbl[3] = '{1, 8, 1, 7, 0, 0, 0,   1, 0, 0, 0, 1};
    tbl[4] = '{1, 8, 1, 9, 0, 0, 1,   1, 1, 1, 7, 2};
    tbl[5] = '{1, 8, 1, 9, 0, 0, 0,   1, 0, 1, 7, 2};
    tbl[6] = '{0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 9, 3};
    tbl[7] = '{1, 8, 0, 0, 1, 0, 0,   1, 0, 0, 0, 2};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2};
    for (int i = 0; i < 9; i++) begin
      rg_valid   = tbl[i].rg_v != 0;
      rg_data    = mk_ray(tbl[i].rg_id, 32'h00C0_DE00 + 32'(tbl[i].rg_id));
      sh_valid   = tbl[i].sh_v != 0;
      sh_data    = mk_ray(tbl[i].sh_id, 32'h0051_AD00 + 32'(tbl[i].sh_id));
      rg_pause   = tbl[i].pause != 0;
      ray_retire = tbl[i].retire != 0;
      sint_stall = tbl[i].stall != 0;
      #1;
      chk("tbl_rg_stall", rg_stall, tbl[i].e_rgs);
      chk("tbl_sh_stall", sh_stall, tbl[i].e_shs);
      chk("tbl_sint_valid", sint_valid, tbl[i].e_val);
      if (tbl[i].e_val != 0) chk("tbl_ray_id", id_of(sint_data), tbl[i].e_id);
      chk("tbl_inflight", inflight, tbl[i].e_inf);
      step();
    end

    // Credit limit: constant raygen, no retire.
    do_reset();
    rid      = 100;
    rg_valid = 1;
    rg_data  = mk_ray(rid, 32'h1);
    grants   = 0;
    repeat (8) begin
      step();
      if (s_rg_xfer) begin
        grants++;
        rid++;
        rg_data = mk_ray(rid, 32'h1);
      end
    end
    chk("credit_grants", grants, 4);
    #1;
    chk("credit_block", rg_stall, 1);
    ray_retire = 1;
    step();
    ray_retire = 0;
    grants = 0;
    repeat (5) begin
      step();
      if (s_rg_xfer) begin
        grants++;
        rid++;
        rg_data = mk_ray(rid, 32'h1);
      end
    end
    chk("credit_one_more", grants, 1);
    ray_retire = 1;
    step();
    step();
    chk("grant_with_retire", s_rg_xfer, 1);
    ray_retire = 0;
    #1;
    chk("grant_retire_inflight", inflight, 3);
    step();

    // Weighted arbitration: both sources always requesting.
    do_reset();
    rg_valid = 1;
    sh_valid = 1;
    rg_data  = mk_ray(1, 32'hAAAA);
    sh_data  = mk_ray(2, 32'hBBBB);
    g = 0;
    n_rg = 0;
    n_sh = 0;
    for (int c = 0; c < 80 && g < 40; c++) begin
      ray_retire = m_inflight > 0;
      step();
      if (s_rg_xfer || s_sh_xfer) begin
        chk("wrr_order", s_rg_xfer, (g % 4) == 3);
        if (s_rg_xfer) n_rg++;
        if (s_sh_xfer) n_sh++;
        g++;
      end
    end
    chk("wrr_rg_share", n_rg, 10);
    chk("wrr_sh_share", n_sh, 30);

    // Pause: raygen must never be forced through.
    rg_pause = 1;
    n_rg = 0;
    n_sh = 0;
    repeat (12) begin
      ray_retire = m_inflight > 0;
      step();
      if (s_rg_xfer) n_rg++;
      if (s_sh_xfer) n_sh++;
    end
    chk("pause_rg_grants", n_rg, 0);
    chk("pause_sh_grants", n_sh, 12);

    // Downstream accepts only on v2.
    do_reset();
    next_id   = 0;
    prev_hold = 0;
    prev_data = '0;
    got.delete();
    for (int c = 0; c < 60 && got.size() < 6; c++) begin
      sint_stall = sint_valid & ~v2;
      sh_valid   = next_id < 6;
      sh_data    = mk_ray(next_id, 32'h5A00 + 32'(next_id));
      ray_retire = sint_valid && !sint_stall;
      if (prev_hold) chk("hold_stable", sint_data, prev_data);
      step();
      if (s_accept) begin
        chk("accept_on_v2", s_v2, 1);
        got.push_back(id_of(s_data));
      end
      if (s_sh_xfer) next_id++;
      prev_hold = s_valid && !s_accept;
      prev_data = s_data;
    end
    chk("sb_count", got.size(), 6);
    for (int i = 0; i < got.size(); i++) chk("sb_id", got[i], i);

    // Asynchronous reset while the output register is stalled.
    do_reset();
    sh_valid   = 1;
    sh_data    = mk_ray(33, 32'h77);
    sint_stall = 1;
    step();
    sh_valid = 0;
    step();
    chk("pre_reset_valid", sint_valid, 1);
    rst = 0;
    #1;
    chk("arst_sint_valid", sint_valid, 0);
    chk("arst_inflight", inflight, 0);
    chk("arst_phase", {v0, v1, v2}, 3'b100);
    chk("arst_idle", idle, 1);
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst = 1;

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if (!rg_valid || s_rg_xfer) begin
        rg_valid = $urandom_range(0, 3) != 0;
        rg_data  = mk_ray(int'($urandom_range(0, 16383)), $urandom);
      end
      if (!sh_valid || s_sh_xfer) begin
        sh_valid = $urandom_range(0, 3) != 0;
        sh_data  = mk_ray(int'($urandom_range(0, 16383)), $urandom);
      end
      if ($urandom_range(0, 7) == 0) rg_pause = ~rg_pause;
      sint_stall = $urandom_range(0, 2) == 0;
      ray_retire = (m_inflight > 0) && ($urandom_range(0, 2) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
